// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and defaults for the fetch sequencer and its ROM wait timer.
// State values are visible on state_o, so the encodings are fixed.
package fetch_seq_pkg;

  localparam int STATE_W = 3;
  localparam int LAT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_STEP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int          ROM_LAT_DEF  = 1;
  localparam logic [11:0] RESET_PC_DEF = 12'h000;
  localparam logic [3:0]  JMP_OP_DEF   = 4'h8;
  localparam logic [3:0]  HLT_OP_DEF   = 4'hF;

  // A JMP target is the saved high nibble followed by the whole second byte.
  function automatic logic [11:0] jmp_target(input logic [3:0] hi,
                                             input logic [3:0] mid,
                                             input logic [3:0] lo);
    return {hi, mid, lo};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between the fetch sequencer and the PC/ROM/fetch datapath.
// master = datapath/environment side, slave = sequencer side.
interface fetch_sequencer_if;
  import fetch_seq_pkg::*;

  logic               start;
  logic               halt_req;
  logic               step_mode;
  logic               step;
  logic [3:0]         instr;
  logic [3:0]         oprnd;
  logic               pc_en;
  logic               pc_load;
  logic [11:0]        pc_load_val;
  logic               fetch_en;
  logic               exec_valid;
  logic [3:0]         exec_instr;
  logic [3:0]         exec_oprnd;
  logic               busy;
  logic               halted;
  logic [STATE_W-1:0] state_o;

  modport master (
    output start, halt_req, step_mode, step, instr, oprnd,
    input  pc_en, pc_load, pc_load_val, fetch_en, exec_valid,
           exec_instr, exec_oprnd, busy, halted, state_o
  );

  modport slave (
    input  start, halt_req, step_mode, step, instr, oprnd,
    output pc_en, pc_load, pc_load_val, fetch_en, exec_valid,
           exec_instr, exec_oprnd, busy, halted, state_o
  );
endinterface

// File: rtl/fetch_sequencer_rom_wait_timer.sv
// ROM wait-state counter: loaded with ROM_LAT when the address settles,
// done marks the last wait cycle (or no wait at all).
module rom_wait_timer
  import fetch_seq_pkg::*;
#(
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam logic [LAT_W-1:0] LAT = LAT_W'(ROM_LAT);

  logic [LAT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LAT;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg <= LAT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller for the PC, program ROM and fetch register.
// All strobes are registered and appear in the cycle of the state they belong to.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int          ROM_LAT  = ROM_LAT_DEF,
  parameter logic [11:0] RESET_PC = RESET_PC_DEF,
  parameter logic [3:0]  JMP_OP   = JMP_OP_DEF,
  parameter logic [3:0]  HLT_OP   = HLT_OP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  localparam bit NO_WAIT = (ROM_LAT == 0);

  state_t      state_reg;
  logic        jmp_pending_reg;
  logic [3:0]  jhi_reg;
  logic [3:0]  exec_instr_reg;
  logic [3:0]  exec_oprnd_reg;
  logic        pc_en_reg;
  logic        pc_load_reg;
  logic [11:0] pc_load_val_reg;
  logic        fetch_en_reg;
  logic        exec_valid_reg;

  logic pc_strobe;
  logic resume;
  logic timer_load;
  logic timer_done;

  // An ADDR cycle carrying a PC strobe is not a wait cycle: the PC only
  // changes at its end, so the ROM wait starts from there.
  assign pc_strobe  = pc_en_reg | pc_load_reg;
  assign resume     = ((state_reg == S_EXEC) && !bus.step_mode) ||
                      ((state_reg == S_STEP) && !bus.halt_req &&
                       (bus.step || !bus.step_mode));
  assign timer_load = resume || ((state_reg == S_ADDR) && pc_strobe);

  rom_wait_timer #(
    .ROM_LAT (ROM_LAT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      jmp_pending_reg <= 1'b0;
      jhi_reg         <= '0;
      exec_instr_reg  <= '0;
      exec_oprnd_reg  <= '0;
      pc_en_reg       <= 1'b0;
      pc_load_reg     <= 1'b0;
      pc_load_val_reg <= '0;
      fetch_en_reg    <= 1'b0;
      exec_valid_reg  <= 1'b0;
    end else begin
      pc_en_reg      <= 1'b0;
      pc_load_reg    <= 1'b0;
      fetch_en_reg   <= 1'b0;
      exec_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state_reg       <= S_ADDR;
            pc_load_reg     <= 1'b1;
            pc_load_val_reg <= RESET_PC;
            jmp_pending_reg <= 1'b0;
          end
        end

        S_ADDR: begin
          if (pc_strobe ? NO_WAIT : timer_done) begin
            state_reg    <= S_FETCH;
            fetch_en_reg <= 1'b1;
          end
        end

        S_FETCH: begin
          state_reg <= S_DECODE;
        end

        S_DECODE: begin
          if (bus.halt_req) begin
            state_reg       <= S_HALT;
            jmp_pending_reg <= 1'b0;
          end else if (jmp_pending_reg) begin
            state_reg       <= S_ADDR;
            pc_load_reg     <= 1'b1;
            pc_load_val_reg <= jmp_target(jhi_reg, bus.instr, bus.oprnd);
            jmp_pending_reg <= 1'b0;
          end else if (bus.instr == HLT_OP) begin
            state_reg <= S_HALT;
          end else if (bus.instr == JMP_OP) begin
            state_reg       <= S_ADDR;
            jhi_reg         <= bus.oprnd;
            pc_en_reg       <= 1'b1;
            jmp_pending_reg <= 1'b1;
          end else begin
            state_reg      <= S_EXEC;
            exec_instr_reg <= bus.instr;
            exec_oprnd_reg <= bus.oprnd;
            exec_valid_reg <= 1'b1;
            pc_en_reg      <= 1'b1;
          end
        end

        // The PC already advanced at the end of EXEC, so with no ROM wait
        // the next byte can be fetched straight away.
        S_EXEC: begin
          if (bus.step_mode) begin
            state_reg <= S_STEP;
          end else if (NO_WAIT) begin
            state_reg    <= S_FETCH;
            fetch_en_reg <= 1'b1;
          end else begin
            state_reg <= S_ADDR;
          end
        end

        S_STEP: begin
          if (bus.halt_req) begin
            state_reg <= S_HALT;
          end else if (bus.step || !bus.step_mode) begin
            if (NO_WAIT) begin
              state_reg    <= S_FETCH;
              fetch_en_reg <= 1'b1;
            end else begin
              state_reg <= S_ADDR;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pc_en       = pc_en_reg;
  assign bus.pc_load     = pc_load_reg;
  assign bus.pc_load_val = pc_load_val_reg;
  assign bus.fetch_en    = fetch_en_reg;
  assign bus.exec_valid  = exec_valid_reg;
  assign bus.exec_instr  = exec_instr_reg;
  assign bus.exec_oprnd  = exec_oprnd_reg;
  assign bus.busy        = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign bus.halted      = (state_reg == S_HALT);
  assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: a PC/ROM/fetch-register model around fetch_sequencer (ROM_LAT=1),
// one task per scenario with hand-computed cycle-exact expectations.
module tb_fetch_sequencer;

  logic clk;
  logic reset;

  fetch_sequencer_if bif ();

  fetch_sequencer #(
    .ROM_LAT  (1),
    .RESET_PC (12'h000),
    .JMP_OP   (4'h8),
    .HLT_OP   (4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: PC, one-cycle registered ROM read, fetch register.
  logic [7:0]  rom [0:4095];
  logic [11:0] pc      = 12'h000;
  logic [7:0]  rom_q   = 8'h00;
  logic [7:0]  fetch_q = 8'h00;

  always @(posedge clk) begin
    if (bif.pc_load)    pc <= bif.pc_load_val;
    else if (bif.pc_en) pc <= pc + 12'd1;
    rom_q <= rom[pc];
    if (bif.fetch_en) fetch_q <= rom_q;
  end

  assign bif.instr = fetch_q[7:4];
  assign bif.oprnd = fetch_q[3:0];

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if ((bif.pc_en && bif.pc_load) || (bif.fetch_en && (bif.pc_en || bif.pc_load))) begin
        n_bad++;
        $display("FAIL strobe_overlap: got pc_en=%b pc_load=%b fetch_en=%b want at most one",
                 bif.pc_en, bif.pc_load, bif.fetch_en);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int k;
    k = 0;
    while (!bif.halted && k < 40) begin
      tick();
      k++;
    end
    n_cmp++;
    if (bif.halted !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_halt_timeout: got halted=%b want 1", name, bif.halted);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bif.pc_en, bif.pc_load, bif.fetch_en, bif.exec_valid, bif.busy, bif.halted} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000000",
               {bif.pc_en, bif.pc_load, bif.fetch_en, bif.exec_valid, bif.busy, bif.halted});
    end
    n_cmp++;
    if (bif.pc_load_val !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_load_val: got %h want 000", bif.pc_load_val);
    end
    n_cmp++;
    if (bif.state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want 0", bif.state_o);
    end
    $display("test_reset: state=%0d", bif.state_o);
  endtask

  task automatic test_sequential();
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hF0;
    do_start();                                   // c1: ADDR with pc_load
    n_cmp++;
    if (bif.pc_load !== 1'b1 || bif.pc_load_val !== 12'h000) begin
      n_bad++;
      $display("FAIL seq_pc_load: got load=%b val=%h want 1/000", bif.pc_load, bif.pc_load_val);
    end
    n_cmp++;
    if (bif.state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL seq_addr_state: got %0d want 1", bif.state_o);
    end
    tick(); tick(); tick();                       // c4: DECODE
    n_cmp++;
    if (bif.state_o !== 3'd3 || bif.exec_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_decode: got state=%0d ev=%b want 3/0", bif.state_o, bif.exec_valid);
    end
    tick();                                       // c5: EXEC 1/2
    n_cmp++;
    if ({bif.exec_valid, bif.pc_en, bif.exec_instr, bif.exec_oprnd} !== {1'b1, 1'b1, 4'h1, 4'h2}) begin
      n_bad++;
      $display("FAIL seq_exec1: got ev=%b pc_en=%b %h/%h want 1/1 1/2",
               bif.exec_valid, bif.pc_en, bif.exec_instr, bif.exec_oprnd);
    end
    tick(); tick(); tick();                       // c8
    n_cmp++;
    if (bif.exec_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_gap: got ev=%b want 0", bif.exec_valid);
    end
    tick();                                       // c9: EXEC 3/4
    n_cmp++;
    if ({bif.exec_valid, bif.pc_en, bif.exec_instr, bif.exec_oprnd} !== {1'b1, 1'b1, 4'h3, 4'h4}) begin
      n_bad++;
      $display("FAIL seq_exec2: got ev=%b pc_en=%b %h/%h want 1/1 3/4",
               bif.exec_valid, bif.pc_en, bif.exec_instr, bif.exec_oprnd);
    end
    tick();                                       // c10: operands hold
    n_cmp++;
    if ({bif.exec_valid, bif.exec_instr, bif.exec_oprnd} !== {1'b0, 4'h3, 4'h4}) begin
      n_bad++;
      $display("FAIL seq_hold: got ev=%b %h/%h want 0 3/4",
               bif.exec_valid, bif.exec_instr, bif.exec_oprnd);
    end
    wait_halt("seq");
    $display("test_sequential: last exec %h/%h", bif.exec_instr, bif.exec_oprnd);
  endtask

  task automatic test_halt_restart();
    int seen;
    n_cmp++;
    if ({bif.halted, bif.busy, bif.exec_valid, bif.state_o} !== {1'b1, 1'b0, 1'b0, 3'd6}) begin
      n_bad++;
      $display("FAIL halt_status: got h=%b b=%b ev=%b st=%0d want 1/0/0/6",
               bif.halted, bif.busy, bif.exec_valid, bif.state_o);
    end
    rom[0] = 8'hF0;
    do_start();
    n_cmp++;
    if ({bif.pc_load, bif.pc_load_val, bif.halted, bif.busy} !== {1'b1, 12'h000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL halt_restart: got load=%b val=%h h=%b b=%b want 1/000/0/1",
               bif.pc_load, bif.pc_load_val, bif.halted, bif.busy);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.exec_valid) seen++;
    end
    n_cmp++;
    if (bif.state_o !== 3'd6 || seen != 0) begin
      n_bad++;
      $display("FAIL halt_op: got state=%0d execs=%0d want 6/0", bif.state_o, seen);
    end
    $display("test_halt_restart: state=%0d", bif.state_o);
  endtask

  task automatic test_jump();
    int seen;
    rom[0] = 8'h81; rom[1] = 8'h2C; rom[12'h12C] = 8'hF0;
    do_start();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.exec_valid) seen++;
    end                                           // c5: ADDR after first JMP byte
    n_cmp++;
    if ({bif.pc_en, bif.pc_load, bif.state_o} !== {1'b1, 1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL jmp_pc_en: got en=%b load=%b st=%0d want 1/0/1",
               bif.pc_en, bif.pc_load, bif.state_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.exec_valid) seen++;
    end                                           // c9: target load
    n_cmp++;
    if ({bif.pc_load, bif.pc_en, bif.pc_load_val} !== {1'b1, 1'b0, 12'h12C}) begin
      n_bad++;
      $display("FAIL jmp_load: got load=%b en=%b val=%h want 1/0/12c",
               bif.pc_load, bif.pc_en, bif.pc_load_val);
    end
    wait_halt("jmp");
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL jmp_no_exec: got %0d exec strobes want 0", seen);
    end
    $display("test_jump: target=%h", bif.pc_load_val);
  endtask

  task automatic test_step();
    int seen;
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56;
    bif.step_mode = 1'b1;
    do_start();
    tick(); tick(); tick(); tick();               // c5: EXEC 1/2
    n_cmp++;
    if ({bif.exec_valid, bif.exec_instr, bif.exec_oprnd} !== {1'b1, 4'h1, 4'h2}) begin
      n_bad++;
      $display("FAIL step_exec1: got ev=%b %h/%h want 1 1/2",
               bif.exec_valid, bif.exec_instr, bif.exec_oprnd);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.exec_valid) seen++;
    end                                           // c9: parked
    n_cmp++;
    if (bif.state_o !== 3'd5 || seen != 0) begin
      n_bad++;
      $display("FAIL step_park: got state=%0d execs=%0d want 5/0", bif.state_o, seen);
    end
    bif.step = 1'b1;
    tick();
    bif.step = 1'b0;                              // c10: ADDR
    n_cmp++;
    if (bif.state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL step_advance: got state=%0d want 1", bif.state_o);
    end
    tick(); tick(); tick();                       // c13: EXEC 3/4
    n_cmp++;
    if ({bif.exec_valid, bif.exec_instr, bif.exec_oprnd} !== {1'b1, 4'h3, 4'h4}) begin
      n_bad++;
      $display("FAIL step_exec2: got ev=%b %h/%h want 1 3/4",
               bif.exec_valid, bif.exec_instr, bif.exec_oprnd);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bif.exec_valid) seen++;
    end
    n_cmp++;
    if (bif.state_o !== 3'd5 || seen != 0) begin
      n_bad++;
      $display("FAIL step_repark: got state=%0d execs=%0d want 5/0", bif.state_o, seen);
    end
    bif.step = 1'b1;
    bif.halt_req = 1'b1;
    tick();
    bif.step = 1'b0;
    bif.halt_req = 1'b0;
    n_cmp++;
    if (bif.state_o !== 3'd6 || bif.halted !== 1'b1) begin
      n_bad++;
      $display("FAIL step_halt: got state=%0d halted=%b want 6/1", bif.state_o, bif.halted);
    end
    bif.step_mode = 1'b0;
    $display("test_step: state=%0d", bif.state_o);
  endtask

  task automatic test_halt_in_jmp();
    rom[0] = 8'h81; rom[1] = 8'h2C; rom[12'h12C] = 8'hF0;
    do_start();
    for (int i = 0; i < 7; i++) tick();           // c8: DECODE of second byte
    n_cmp++;
    if (bif.state_o !== 3'd3) begin
      n_bad++;
      $display("FAIL hjmp_decode: got state=%0d want 3", bif.state_o);
    end
    bif.halt_req = 1'b1;
    tick();
    bif.halt_req = 1'b0;
    n_cmp++;
    if ({bif.state_o, bif.pc_load} !== {3'd6, 1'b0}) begin
      n_bad++;
      $display("FAIL hjmp_halt: got state=%0d load=%b want 6/0", bif.state_o, bif.pc_load);
    end
    // A stale jmp_pending would turn the first JMP byte into a load of 12'h181.
    do_start();
    tick(); tick(); tick(); tick();               // c5
    n_cmp++;
    if ({bif.pc_en, bif.pc_load} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL hjmp_cleared: got en=%b load=%b val=%h want 1/0",
               bif.pc_en, bif.pc_load, bif.pc_load_val);
    end
    tick(); tick(); tick(); tick();               // c9
    n_cmp++;
    if ({bif.pc_load, bif.pc_load_val} !== {1'b1, 12'h12C}) begin
      n_bad++;
      $display("FAIL hjmp_rerun: got load=%b val=%h want 1/12c", bif.pc_load, bif.pc_load_val);
    end
    wait_halt("hjmp");
    $display("test_halt_in_jmp: state=%0d", bif.state_o);
  endtask

  task automatic test_reset_mid_exec();
    int bad_cycles;
    rom[0] = 8'h12; rom[1] = 8'h34;
    do_start();
    tick(); tick(); tick(); tick();               // c5: EXEC
    n_cmp++;
    if (bif.exec_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_exec: got ev=%b want 1", bif.exec_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bif.pc_en, bif.pc_load, bif.fetch_en, bif.exec_valid, bif.busy, bif.halted, bif.state_o}
        !== 9'b0) begin
      n_bad++;
      $display("FAIL rst_async: got en=%b ld=%b fe=%b ev=%b b=%b h=%b st=%0d want all 0",
               bif.pc_en, bif.pc_load, bif.fetch_en, bif.exec_valid, bif.busy, bif.halted,
               bif.state_o);
    end
    tick();
    reset = 1'b0;
    bad_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bif.pc_en !== 1'b0 || bif.state_o !== 3'd0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL rst_release: got %0d active cycles want 0", bad_cycles);
    end
    $display("test_reset_mid_exec: state=%0d", bif.state_o);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    reset         = 1'b1;
    bif.start     = 1'b0;
    bif.halt_req  = 1'b0;
    bif.step_mode = 1'b0;
    bif.step      = 1'b0;
    #12;
    test_reset();
    tick();
    reset = 1'b0;
    tick();
    test_sequential();
    test_halt_restart();
    test_jump();
    test_step();
    test_halt_in_jmp();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
